// File: rtl/maxnet_ctrl.sv
// Sequencing controller for the Maxnet winner-take-all datapath: load, check, compute, update.
// Optional iteration limit enabled by defining MAXNET_TIMEOUT_EN.
module maxnet_ctrl #(
   parameter int N        = 4,
   parameter int IDX_W    = 2,
   parameter int CNT_W    = 8,
   parameter int CALC_LAT = 2,
   parameter int MAX_ITER = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N-1:0]     nz,
   output logic             busy,
   output logic             ld_init,
   output logic             sel_init,
   output logic             ld_update,
   output logic             done,
   output logic [IDX_W-1:0] winner,
   output logic             no_winner,
   output logic             timeout,
   output logic [CNT_W-1:0] iter_cnt,
   output logic [2:0]       dbg_state
);

   // start/busy handshake: start is accepted only on a cycle where busy is low (IDLE);
   // it is ignored otherwise, and a held start relaunches once DONE returns to IDLE.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_CHECK  = 3'd2,
      S_CALC   = 3'd3,
      S_UPDATE = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   localparam int              WAIT_W    = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(CALC_LAT - 1);

   state_t             r_state;
   state_t             w_next;
   logic [WAIT_W-1:0]  r_wait;
   logic [IDX_W-1:0]   r_winner;
   logic               r_no_winner;
   logic [CNT_W-1:0]   r_iter;
   logic               w_seen;
   logic               w_multi;
   logic [IDX_W-1:0]   w_low_idx;
   logic               w_limit;

   // Scan high to low so the last hit is the lowest set index; a second hit marks >1 active.
   always_comb begin
      w_seen    = 1'b0;
      w_multi   = 1'b0;
      w_low_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (nz[i]) begin
            w_multi   = w_multi | w_seen;
            w_seen    = 1'b1;
            w_low_idx = IDX_W'(i);
         end
      end
   end

`ifdef MAXNET_TIMEOUT_EN
   logic r_timeout;
   assign w_limit = (r_iter == CNT_W'(MAX_ITER));
   assign timeout = r_timeout;
`else
   assign w_limit = 1'b0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      busy      = 1'b1;
      ld_init   = 1'b0;
      sel_init  = 1'b0;
      ld_update = 1'b0;
      done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) w_next = S_LOAD;
         end
         S_LOAD: begin
            ld_init  = 1'b1;
            sel_init = 1'b1;
            w_next   = S_CHECK;
         end
         S_CHECK:  w_next = (w_multi && !w_limit) ? S_CALC : S_DONE;
         S_CALC:   if (r_wait == '0) w_next = S_UPDATE;
         S_UPDATE: begin
            ld_update = 1'b1;
            w_next    = S_CHECK;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            busy   = 1'b0;
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait      <= '0;
         r_winner    <= '0;
         r_no_winner <= 1'b0;
         r_iter      <= '0;
`ifdef MAXNET_TIMEOUT_EN
         r_timeout   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_winner    <= '0;
                  r_no_winner <= 1'b0;
                  r_iter      <= '0;
`ifdef MAXNET_TIMEOUT_EN
                  r_timeout   <= 1'b0;
`endif
               end
            end
            S_CHECK: begin
               if (!w_seen) begin
                  r_no_winner <= 1'b1;
                  r_winner    <= '0;
               end else if (!w_multi) begin
                  r_winner <= w_low_idx;
               end else if (w_limit) begin
                  r_winner <= w_low_idx;
`ifdef MAXNET_TIMEOUT_EN
                  r_timeout <= 1'b1;
`endif
               end else begin
                  r_wait <= WAIT_INIT;
               end
            end
            S_CALC: if (r_wait != '0) r_wait <= r_wait - 1'b1;
            S_UPDATE: if (r_iter != '1) r_iter <= r_iter + 1'b1;
            default: ;
         endcase
      end
   end

   assign winner    = r_winner;
   assign no_winner = r_no_winner;
   assign iter_cnt  = r_iter;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_maxnet_ctrl.sv
// Directed bench for maxnet_ctrl; the neuron registers are modelled by reloading nz after
// each ld_init/ld_update edge from a per-run sequence table.
module tb_maxnet_ctrl;

   localparam int N     = 4;
   localparam int IDX_W = 2;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [N-1:0]     nz;
   logic             busy, ld_init, sel_init, ld_update, done, no_winner, timeout;
   logic [IDX_W-1:0] winner;
   logic [CNT_W-1:0] iter_cnt;
   logic [2:0]       dbg_state;

   maxnet_ctrl #(
      .N(N), .IDX_W(IDX_W), .CNT_W(CNT_W), .CALC_LAT(2), .MAX_ITER(3)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .nz(nz),
      .busy(busy), .ld_init(ld_init), .sel_init(sel_init), .ld_update(ld_update),
      .done(done), .winner(winner), .no_winner(no_winner), .timeout(timeout),
      .iter_cnt(iter_cnt), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [N-1:0] seq [0:7];
   int seq_len;
   int n_init, n_upd, upd_gap, done_cyc, both_cnt;
   bit got_done;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at #1 after an edge with the DUT in IDLE; cycle 0 is the LOAD cycle.
   task automatic run_seq(input int max_cyc);
      int k;
      int last;
      bit p_init, p_upd;
      n_init = 0; n_upd = 0; upd_gap = -1; got_done = 0; done_cyc = -1; both_cnt = 0;
      last = -1; k = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < max_cyc; c++) begin
         if (ld_init && ld_update) both_cnt++;
         if (ld_init) n_init++;
         if (ld_update) begin
            n_upd++;
            if (last >= 0) upd_gap = c - last;
            last = c;
         end
         if (done) begin
            got_done = 1'b1;
            done_cyc = c;
            break;
         end
         p_init = ld_init;
         p_upd  = ld_update;
         @(posedge clk); #1;
         if (p_init) begin
            k  = 0;
            nz = seq[0];
         end
         if (p_upd) begin
            if (k < seq_len - 1) k++;
            nz = seq[k];
         end
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; nz = '0;
      step(); step();
      check_eq("reset_outs", {busy, ld_init, sel_init, ld_update, done, no_winner, timeout,
                              winner, iter_cnt, dbg_state}, 32'd0);
      rst = 1'b0;
      step();

      // Single active neuron: LOAD, CHECK, DONE.
      seq[0] = 4'b0100; seq_len = 1;
      run_seq(20);
      check_eq("t2_done_seen", 32'(got_done), 32'd1);
      check_eq("t2_done_cyc", done_cyc, 2);
      check_eq("t2_n_init", n_init, 1);
      check_eq("t2_n_upd", n_upd, 0);
      check_eq("t2_winner", 32'(winner), 32'd2);
      check_eq("t2_iter", 32'(iter_cnt), 32'd0);
      check_eq("t2_flags", {no_winner, timeout}, 32'd0);
      step();
      check_eq("t2_idle_after", {busy, done}, 32'd0);

      // Two iterations before a single survivor.
      seq[0] = 4'b1011; seq[1] = 4'b1011; seq[2] = 4'b1000; seq_len = 3;
      run_seq(40);
      check_eq("t3_done_seen", 32'(got_done), 32'd1);
      check_eq("t3_done_cyc", done_cyc, 10);
      check_eq("t3_n_upd", n_upd, 2);
      check_eq("t3_upd_gap", upd_gap, 4);
      check_eq("t3_both_ld", both_cnt, 0);
      check_eq("t3_winner", 32'(winner), 32'd3);
      check_eq("t3_iter", 32'(iter_cnt), 32'd2);
      check_eq("t3_no_winner", 32'(no_winner), 32'd0);
      step();

      // Asynchronous reset between edges clears the held results immediately.
      #2 rst = 1'b1;
      #1;
      check_eq("t1_async_rst", {busy, ld_init, sel_init, ld_update, done, no_winner, timeout,
                                winner, iter_cnt, dbg_state}, 32'd0);
      @(posedge clk); #3 rst = 1'b0;
      step();

      // All activations die after the first update.
      seq[0] = 4'b0110; seq[1] = 4'b0000; seq_len = 2;
      run_seq(40);
      check_eq("t4_done_seen", 32'(got_done), 32'd1);
      check_eq("t4_done_cyc", done_cyc, 6);
      check_eq("t4_no_winner", 32'(no_winner), 32'd1);
      check_eq("t4_winner", 32'(winner), 32'd0);
      check_eq("t4_iter", 32'(iter_cnt), 32'd1);
      check_eq("t4_n_upd", n_upd, 1);
      step();

      // Reset during CALC, then a fresh run counts from zero.
      nz = 4'b1011; start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      check_eq("t5_in_calc", {busy, sel_init, dbg_state}, {30'd0, 1'b1, 1'b0} << 3 | 32'd3);
      rst = 1'b1;
      #1;
      check_eq("t5_rst_now", {busy, ld_init, ld_update, dbg_state}, 32'd0);
      step();
      check_eq("t5_rst_next", {busy, ld_init, ld_update}, 32'd0);
      rst = 1'b0;
      begin
         int ld_seen;
         ld_seen = 0;
         for (int i = 0; i < 4; i++) begin
            step();
            if (ld_init || ld_update || busy) ld_seen++;
         end
         check_eq("t5_quiet_after_rst", ld_seen, 0);
      end
      seq[0] = 4'b0111; seq[1] = 4'b0011; seq[2] = 4'b0010; seq_len = 3;
      run_seq(40);
      check_eq("t5_fresh_done", 32'(got_done), 32'd1);
      check_eq("t5_fresh_winner", 32'(winner), 32'd1);
      check_eq("t5_fresh_iter", 32'(iter_cnt), 32'd2);
      step();

      // start held high through DONE relaunches right after IDLE.
      nz = 4'b1000; start = 1'b1;
      step();
      check_eq("hold_load1", 32'(ld_init), 32'd1);
      step(); step();
      check_eq("hold_done1", 32'(done), 32'd1);
      step();
      check_eq("hold_idle", 32'(busy), 32'd0);
      step();
      check_eq("hold_load2", {ld_init, sel_init}, 32'd3);
      start = 1'b0;
      step(); step();
      check_eq("hold_done2", {done, winner}, {30'd0, 1'b1, 2'd3});
      step();

      // Stuck at two active neurons.
      seq[0] = 4'b0110; seq_len = 1;
      run_seq(40);
`ifdef MAXNET_TIMEOUT_EN
      check_eq("t6_done_seen", 32'(got_done), 32'd1);
      check_eq("t6_done_cyc", done_cyc, 14);
      check_eq("t6_n_upd", n_upd, 3);
      check_eq("t6_timeout", 32'(timeout), 32'd1);
      check_eq("t6_winner", 32'(winner), 32'd1);
      check_eq("t6_iter", 32'(iter_cnt), 32'd3);
`else
      check_eq("t6_no_done", 32'(got_done), 32'd0);
      check_eq("t6_busy", 32'(busy), 32'd1);
      check_eq("t6_n_upd", n_upd, 9);
      check_eq("t6_iter", 32'(iter_cnt), 32'd9);
      check_eq("t6_timeout", 32'(timeout), 32'd0);
`endif
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/maxnet_ctrl.md
Name: maxnet_ctrl

Overview:
Sequencing controller for the Maxnet winner-take-all datapath. Drives load enables of the neuron activation registers (clear-on-reset, load-enabled registers), waits for the datapath's update computation, and checks the per-neuron nonzero flags after every iteration. Stops when exactly one neuron remains active, or none remain, and reports the winner index and iteration count.

Parameters:
N, 4, number of neurons / width of nonzero-flag vector
IDX_W, 2, winner index width (clog2(N))
CNT_W, 8, iteration counter width
CALC_LAT, 2, cycles the datapath needs to compute the next activations (>=1)
MAX_ITER, 255, iteration limit (used only with the optional feature)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a run; sampled only in IDLE
nz  input  N  per-neuron activation != 0 flags, from the datapath registers
busy  output  1  high in every state except IDLE
ld_init  output  1  load enable, initial activations into neuron registers
sel_init  output  1  datapath mux select: 1 = external inputs, 0 = update result
ld_update  output  1  load enable, updated activations into neuron registers
done  output  1  one-cycle pulse when a run finishes
winner  output  IDX_W  index of the surviving neuron
no_winner  output  1  run ended with all activations zero
timeout  output  1  run ended on the iteration limit
iter_cnt  output  CNT_W  iterations completed in the current/last run

Behaviour:
- Registered state; ld_init, sel_init, ld_update, busy and done are Moore outputs decoded from state. winner, no_winner, timeout and iter_cnt are registers.
- Reset (any time, including mid-run): state=IDLE; all outputs 0; internal wait counter 0. No further ld pulses occur until a new start.
- States: IDLE, LOAD, CHECK, CALC, UPDATE, DONE.
- IDLE: start=1 -> LOAD. Clear winner, no_winner, timeout and iter_cnt on the same edge. start=0 -> stay in IDLE.
- LOAD (1 cycle): ld_init=1, sel_init=1 -> CHECK.
- CHECK (1 cycle): evaluate nz, which reflects the register contents loaded on the previous edge.
  - popcount(nz)==1 -> DONE; winner <= index of the set bit.
  - popcount(nz)==0 -> DONE; no_winner <= 1, winner <= 0.
  - popcount(nz)>1 -> CALC; load the wait counter with CALC_LAT-1.
- CALC: all load enables 0, sel_init=0. Decrement the wait counter each cycle; when the counter is 0 -> UPDATE. Dwell is exactly CALC_LAT cycles.
- UPDATE (1 cycle): ld_update=1, sel_init=0. iter_cnt <= iter_cnt+1, saturating at 2^CNT_W-1 -> CHECK.
- DONE (1 cycle): done=1 -> IDLE. Result registers hold until the next accepted start.
- start is ignored while busy=1. If start is held high through DONE, a new run begins on the cycle after DONE returns to IDLE.
- Only one of ld_init and ld_update is ever high in a cycle.
- An input that already has exactly one active neuron finishes with iter_cnt=0: start, LOAD, CHECK, DONE.
- Per-iteration cost is CALC_LAT+2 cycles.

Optional Feature:
Macro MAXNET_TIMEOUT_EN.
- Defined: in CHECK, if popcount(nz)>1 and iter_cnt==MAX_ITER -> DONE with timeout<=1 and winner <= lowest set index of nz.
- Undefined: timeout is tied to 0, there is no iteration limit, and iter_cnt saturates as described.

Test Plan:
1. Assert rst mid-cycle with no clock edge -> all outputs read 0 immediately; state IDLE.
2. start pulse with nz=4'b0100 (N=4, CALC_LAT=2) -> ld_init high 1 cycle; done pulse 2 cycles after LOAD; winner=2, iter_cnt=0, ld_update never high.
3. start with nz=4'b1011 for the first two CHECKs, then 4'b1000 -> ld_update pulses exactly twice, 4 cycles apart; done asserted; winner=3, iter_cnt=2, no_winner=0.
4. nz=4'b0110 then 4'b0000 after the first update -> done with no_winner=1, winner=0, iter_cnt=1.
5. Assert rst during CALC of a run -> next cycle: busy=0, ld_* = 0; a fresh start then completes normally with iter_cnt counted from 0.
6. MAXNET_TIMEOUT_EN defined, MAX_ITER=3, nz stuck at 4'b0110 -> done after 3 ld_update pulses; timeout=1, winner=1, iter_cnt=3. Without the macro, the same stimulus keeps busy=1 indefinitely.
